// File: rtl/mc_ctrl_fsm_if.sv
// Control-path bundle between the multi-cycle controller and its datapath/memory.
// The controller takes the slave side; whoever drives instructions and memory handshakes takes master.
interface mc_ctrl_fsm_if;
   logic [31:0] instr;
   logic        mem_ready;
   logic        br_taken;
   logic        mem_req;
   logic        mem_we;
   logic        iord;
   logic        ir_we;
   logic        pc_we;
   logic [1:0]  pc_sel;
   logic        rf_we;
   logic [2:0]  imm_sel;
   logic [1:0]  alu_src_a;
   logic        alu_src_b;
   logic [1:0]  wb_sel;
   logic [2:0]  state;
   logic        illegal;
   logic        retire;
   logic [31:0] instret;

   modport slave (
      input  instr, mem_ready, br_taken,
      output mem_req, mem_we, iord, ir_we, pc_we, pc_sel, rf_we, imm_sel,
             alu_src_a, alu_src_b, wb_sel, state, illegal, retire, instret
   );

   modport master (
      output instr, mem_ready, br_taken,
      input  mem_req, mem_we, iord, ir_we, pc_we, pc_sel, rf_we, imm_sel,
             alu_src_a, alu_src_b, wb_sel, state, illegal, retire, instret
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP on illegal opcodes.
// Strobes are combinational decodes of state/opcode/handshakes, forced low while reset is held.
module mc_ctrl_fsm (
   input  logic         clk,
   input  logic         rst_n,
   mc_ctrl_fsm_if.slave bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   state_t      r_state;
   state_t      w_next;
   logic        r_illegal;
   logic [31:0] r_instret;

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic        w_is_r, w_is_imm, w_is_load, w_is_store, w_is_br;
   logic        w_is_jal, w_is_jalr, w_is_lui, w_is_auipc, w_legal;
   logic [2:0]  w_imm_sel;

   logic        w_mem_req, w_mem_we, w_iord, w_ir_we, w_pc_we, w_rf_we, w_retire;
   logic [1:0]  w_pc_sel, w_alu_a, w_wb_sel;
   logic        w_alu_b;
   logic        w_unused_instr;

   assign w_opc      = bus.instr[6:0];
   assign w_f3       = bus.instr[14:12];
   assign w_is_r     = (w_opc == OPC_R);
   assign w_is_imm   = (w_opc == OPC_IMM);
   assign w_is_load  = (w_opc == OPC_LOAD);
   assign w_is_store = (w_opc == OPC_STORE);
   assign w_is_br    = (w_opc == OPC_BR);
   assign w_is_jal   = (w_opc == OPC_JAL);
   assign w_is_jalr  = (w_opc == OPC_JALR);
   assign w_is_lui   = (w_opc == OPC_LUI);
   assign w_is_auipc = (w_opc == OPC_AUIPC);
   assign w_legal    = w_is_r | w_is_imm | w_is_load | w_is_store | w_is_br |
                       w_is_jal | w_is_jalr | w_is_lui | w_is_auipc;

   // Only opcode and funct3 steer control; the rest of the word belongs to the datapath.
   assign w_unused_instr = ^{bus.instr[31:15], bus.instr[11:7]};

   always_comb begin
      w_imm_sel = 3'd0;
      unique case (w_opc)
         OPC_IMM:            w_imm_sel = (w_f3 == 3'b001 || w_f3 == 3'b101) ? 3'd6 : 3'd1;
         OPC_LOAD, OPC_JALR: w_imm_sel = 3'd1;
         OPC_STORE:          w_imm_sel = 3'd2;
         OPC_BR:             w_imm_sel = 3'd3;
         OPC_LUI, OPC_AUIPC: w_imm_sel = 3'd4;
         OPC_JAL:            w_imm_sel = 3'd5;
         default:            w_imm_sel = 3'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_illegal <= 1'b0;
         r_instret <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP)
            r_illegal <= 1'b1;
         if (w_retire)
            r_instret <= r_instret + 32'd1;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_mem_req = 1'b0;
      w_mem_we  = 1'b0;
      w_iord    = 1'b0;
      w_ir_we   = 1'b0;
      w_pc_we   = 1'b0;
      w_pc_sel  = 2'd0;
      w_rf_we   = 1'b0;
      w_alu_a   = 2'd0;
      w_alu_b   = 1'b0;
      w_wb_sel  = 2'd0;
      w_retire  = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req = 1'b1;
            if (bus.mem_ready) begin
               w_ir_we = 1'b1;
               w_next  = S_DECODE;
            end
         end
         S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            w_alu_a = w_is_auipc ? 2'd1 : (w_is_lui ? 2'd2 : 2'd0);
            w_alu_b = w_is_imm | w_is_load | w_is_store | w_is_jalr | w_is_auipc | w_is_lui;
            if (w_is_br) begin
               w_pc_we  = 1'b1;
               w_pc_sel = bus.br_taken ? 2'd1 : 2'd0;
               w_retire = 1'b1;
               w_next   = S_FETCH;
            end else if (w_is_load || w_is_store) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            // iord/mem_we depend only on state and the held opcode, so they stay put across waits.
            w_mem_req = 1'b1;
            w_iord    = 1'b1;
            w_mem_we  = w_is_store;
            if (bus.mem_ready) begin
               if (w_is_store) begin
                  w_pc_we  = 1'b1;
                  w_retire = 1'b1;
                  w_next   = S_FETCH;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            w_rf_we  = 1'b1;
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_wb_sel = w_is_load ? 2'd1 : ((w_is_jal || w_is_jalr) ? 2'd2 : 2'd0);
            w_pc_sel = w_is_jal ? 2'd1 : (w_is_jalr ? 2'd2 : 2'd0);
            w_next   = S_FETCH;
         end
         S_TRAP:  w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
   end

   // Reset gates every strobe so an abandoned instruction cannot touch PC, RF or memory.
   assign bus.mem_req   = w_mem_req & rst_n;
   assign bus.mem_we    = w_mem_we  & rst_n;
   assign bus.ir_we     = w_ir_we   & rst_n;
   assign bus.pc_we     = w_pc_we   & rst_n;
   assign bus.rf_we     = w_rf_we   & rst_n;
   assign bus.retire    = w_retire  & rst_n;
   assign bus.iord      = w_iord;
   assign bus.pc_sel    = w_pc_sel;
   assign bus.imm_sel   = w_imm_sel;
   assign bus.alu_src_a = w_alu_a;
   assign bus.alu_src_b = w_alu_b;
   assign bus.wb_sel    = w_wb_sel;
   assign bus.state     = r_state;
   assign bus.illegal   = r_illegal;
   assign bus.instret   = r_instret;

endmodule
